// File: rtl/ttl_bcd_count_sequencer.sv
// -----------------------------------------------------------------------------
// ttl_bcd_count_sequencer
//
// Control source for a cascaded chain of synchronous BCD decade counters
// (for example a ttl_74162 chain). It runs a preset-to-terminal count,
// reloads the preset and repeats for a programmed number of passes. Runs can
// be paused, resumed, aborted or cleared.
//
// Optional feature macro: SEQ_AUTO_RELOAD_EN
//   defined   : DONE lasts one cycle (Done pulses), then the run restarts
//               from LOAD with the same latched target, indefinitely, until
//               Clear_req or Reset.
//   undefined : DONE is held (Done=1) until Start restarts or Clear_req clears.
//
// Parameters
//   REPEAT_WIDTH : width of Repeat and Pass_count
//   DELAY_RISE   : rise delay of the outputs (time attribute of the TTL
//                  library; this synthesizable model is zero-delay)
//   DELAY_FALL   : fall delay of the outputs (as above)
//
// Ports
//   Clk        in   rising-edge clock, shared with the counter chain
//   Reset      in   synchronous active-high reset, forces IDLE
//   Start      in   begin a run (IDLE/DONE) or resume (HOLD)
//   Stop       in   pause a run (RUN -> HOLD)
//   Clear_req  in   clear the chain, aborts any run
//   Repeat     in   number of passes, 0 treated as 1, sampled on Start
//   RCO_chain  in   RCO of the last chain stage
//   Clear_bar  out  to every stage's Clear_bar
//   Load_bar   out  to every stage's Load_bar
//   ENP        out  to every stage's ENP
//   ENT        out  to the first stage's ENT
//   Busy       out  high in LOAD, RUN, HOLD
//   Done       out  high in DONE
//   Pass_count out  passes completed in the current or last run
//   State_dbg  out  current FSM state encoding, for checkers and debug
//
// Handshake note: there is no valid/ready pairing here. Start, Stop and
// Clear_req are level requests sampled on every rising edge; a request that
// is not acted on in the state where it is sampled is dropped, and the
// requester must re-assert it. All outputs are registered decodes of the
// next state, so no input reaches an output within the same cycle.
// -----------------------------------------------------------------------------
module ttl_bcd_count_sequencer #(
  parameter int REPEAT_WIDTH = 8,
  parameter int DELAY_RISE   = 0,
  parameter int DELAY_FALL   = 0
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic                    Stop,
  input  logic                    Clear_req,
  input  logic [REPEAT_WIDTH-1:0] Repeat,
  input  logic                    RCO_chain,
  output logic                    Clear_bar,
  output logic                    Load_bar,
  output logic                    ENP,
  output logic                    ENT,
  output logic                    Busy,
  output logic                    Done,
  output logic [REPEAT_WIDTH-1:0] Pass_count,
  output logic [2:0]              State_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [REPEAT_WIDTH-1:0] REPEAT_ONE = REPEAT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [REPEAT_WIDTH-1:0] pass_q, pass_d;
  logic [REPEAT_WIDTH-1:0] target_q, target_d;
  logic [REPEAT_WIDTH-1:0] pass_inc;
  logic [REPEAT_WIDTH-1:0] repeat_eff;

  // Registered control/status outputs and their next values.
  logic clear_bar_q, load_bar_q, enp_q, ent_q, busy_q, done_q;
  logic clear_bar_d, load_bar_d, enp_d, ent_d, busy_d, done_d;

  // pass_q is always below target_q while running, so the increment
  // cannot wrap.
  assign pass_inc   = pass_q + 1'b1;
  assign repeat_eff = (Repeat == '0) ? REPEAT_ONE : Repeat;

  // ---------------------------------------------------------------------------
  // Next-state logic. Clear_req outranks every other input; Reset is handled
  // in the state register and outranks Clear_req.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    target_d = target_q;

    if (Clear_req) begin
      // Pass_count is deliberately held so the aborted run stays visible.
      state_d = S_CLEAR;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            target_d = repeat_eff;
            pass_d   = '0;
            state_d  = S_LOAD;
          end
        end

        S_CLEAR: begin
          state_d = S_IDLE;
        end

        S_LOAD: begin
          // The chain takes its preset on the edge leaving LOAD.
          state_d = S_RUN;
        end

        S_RUN: begin
          // Terminal count beats Stop: the chain wraps on this edge either
          // way, so the pass must be accounted for now.
          if (RCO_chain) begin
            pass_d = pass_inc;
            if (pass_inc == target_q) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
            end
          end else if (Stop) begin
            state_d = S_HOLD;
          end
        end

        S_HOLD: begin
          if (Start) begin
            state_d = S_RUN;
          end
        end

        S_DONE: begin
`ifdef SEQ_AUTO_RELOAD_EN
          // Free-running mode: restart with the same target after one cycle.
          pass_d  = '0;
          state_d = S_LOAD;
`else
          if (Start) begin
            target_d = repeat_eff;
            pass_d   = '0;
            state_d  = S_LOAD;
          end
`endif
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode of the next state, registered alongside the state so every
  // output is a clean flop that matches the state it describes.
  // ---------------------------------------------------------------------------
  always_comb begin
    clear_bar_d = 1'b1;
    load_bar_d  = 1'b1;
    enp_d       = 1'b0;
    ent_d       = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_d)
      S_CLEAR: begin
        clear_bar_d = 1'b0;
      end
      S_LOAD: begin
        load_bar_d = 1'b0;
        busy_d     = 1'b1;
      end
      S_RUN: begin
        enp_d  = 1'b1;
        ent_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_HOLD: begin
        // ENT stays high so the chain's RCO remains observable while frozen.
        ent_d  = 1'b1;
        busy_d = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      pass_q      <= '0;
      target_q    <= REPEAT_ONE;
      clear_bar_q <= 1'b1;
      load_bar_q  <= 1'b1;
      enp_q       <= 1'b0;
      ent_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pass_q      <= pass_d;
      target_q    <= target_d;
      clear_bar_q <= clear_bar_d;
      load_bar_q  <= load_bar_d;
      enp_q       <= enp_d;
      ent_q       <= ent_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage. The rise/fall delays describe the TTL parts being modelled
  // and have no meaning in a synthesized netlist, so both branches connect
  // the registers straight through.
  // ---------------------------------------------------------------------------
  if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_out_zero_delay
    assign Clear_bar  = clear_bar_q;
    assign Load_bar   = load_bar_q;
    assign ENP        = enp_q;
    assign ENT        = ent_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Pass_count = pass_q;
  end else begin : g_out_timed
    assign Clear_bar  = clear_bar_q;
    assign Load_bar   = load_bar_q;
    assign ENP        = enp_q;
    assign ENT        = ent_q;
    assign Busy       = busy_q;
    assign Done       = done_q;
    assign Pass_count = pass_q;
  end

  assign State_dbg = state_q;

endmodule

// File: tb/tb_ttl_bcd_count_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for ttl_bcd_count_sequencer. A behavioural two-digit BCD counter
// chain (two cascaded decade counters, clear > load > count) sits beside the
// sequencer. Expected values come from pass-timing arithmetic: a pass from
// preset P costs one LOAD edge plus (100 - P) RUN edges, and a pause costs
// exactly the number of HOLD edges.
// -----------------------------------------------------------------------------
module tb_ttl_bcd_count_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Stop;
  logic       Clear_req;
  logic [7:0] Repeat;
  logic       RCO_chain;
  logic       Clear_bar;
  logic       Load_bar;
  logic       ENP;
  logic       ENT;
  logic       Busy;
  logic       Done;
  logic [7:0] Pass_count;
  logic [2:0] State_dbg;

  int tests_run = 0;
  int fails     = 0;

  // Counter chain model: value held as a decimal 0..99.
  logic [7:0] d_bcd = 8'h95;
  int         chain_val = 0;

  ttl_bcd_count_sequencer #(
    .REPEAT_WIDTH(8),
    .DELAY_RISE  (0),
    .DELAY_FALL  (0)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Stop      (Stop),
    .Clear_req (Clear_req),
    .Repeat    (Repeat),
    .RCO_chain (RCO_chain),
    .Clear_bar (Clear_bar),
    .Load_bar  (Load_bar),
    .ENP       (ENP),
    .ENT       (ENT),
    .Busy      (Busy),
    .Done      (Done),
    .Pass_count(Pass_count),
    .State_dbg (State_dbg)
  );

  // Clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (!Clear_bar) chain_val <= 0;
    else if (!Load_bar) chain_val <= int'(d_bcd[7:4]) * 10 + int'(d_bcd[3:0]);
    else if (ENP && ENT) chain_val <= (chain_val == 99) ? 0 : chain_val + 1;
  end

  assign RCO_chain = ENT && (chain_val == 99);

  // Advance one edge and sample away from it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Return to IDLE between scenarios.
  task automatic clear_chain();
    Start = 1'b0; Stop = 1'b0; Clear_req = 1'b1;
    step();
    Clear_req = 1'b0;
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Clear_req = 1'b0; Repeat = 8'd1;
    step(); step();
    Reset = 1'b0;
    tests_run++; if ({Clear_bar, Load_bar} !== 2'b11) begin fails++; $display("FAIL reset_bars: got %b expected 11", {Clear_bar, Load_bar}); end
    tests_run++; if ({ENP, ENT} !== 2'b00) begin fails++; $display("FAIL reset_enables: got %b expected 00", {ENP, ENT}); end
    tests_run++; if ({Busy, Done} !== 2'b00) begin fails++; $display("FAIL reset_status: got %b expected 00", {Busy, Done}); end
    tests_run++; if (Pass_count !== 8'd0) begin fails++; $display("FAIL reset_pass: got %0d expected 0", Pass_count); end
  endtask

  // Preset 95, one pass, with an ignored Start while running.
  task automatic test_single_pass();
    d_bcd = 8'h95; Repeat = 8'd1;
    Start = 1'b1; step(); Start = 1'b0;                      // edge 0
    tests_run++; if ({Load_bar, Busy, ENP} !== 3'b010) begin fails++; $display("FAIL sp_load: got %b expected 010", {Load_bar, Busy, ENP}); end
    step();                                                  // edge 1
    tests_run++; if (chain_val !== 95) begin fails++; $display("FAIL sp_preset: got %0d expected 95", chain_val); end
    tests_run++; if ({Load_bar, ENP, ENT} !== 3'b111) begin fails++; $display("FAIL sp_run: got %b expected 111", {Load_bar, ENP, ENT}); end
    Start = 1'b1; step(); Start = 1'b0;                      // edge 2, Start ignored
    step(); step(); step();                                  // edge 5
    tests_run++; if (chain_val !== 99 || RCO_chain !== 1'b1 || Done !== 1'b0) begin fails++; $display("FAIL sp_terminal: got chain %0d rco %b done %b expected 99 1 0", chain_val, RCO_chain, Done); end
    step();                                                  // edge 6
    tests_run++; if (chain_val !== 0) begin fails++; $display("FAIL sp_wrap: got %0d expected 0", chain_val); end
    tests_run++; if ({Done, Busy, ENP} !== 3'b100 || Pass_count !== 8'd1) begin fails++; $display("FAIL sp_done: got dbe %b pass %0d expected 100 1", {Done, Busy, ENP}, Pass_count); end
    Clear_req = 1'b1; step(); Clear_req = 1'b0;
    tests_run++; if ({Clear_bar, Busy, Done} !== 3'b000 || Pass_count !== 8'd1) begin fails++; $display("FAIL sp_clear: got cbd %b pass %0d expected 000 1", {Clear_bar, Busy, Done}, Pass_count); end
    step();
    tests_run++; if (Clear_bar !== 1'b1) begin fails++; $display("FAIL sp_clear_one_cycle: got %b expected 1", Clear_bar); end
  endtask

  // Preset 97, three passes of four edges each, Repeat changed after latch.
  task automatic test_multi_pass();
    int exp_pass;
    d_bcd = 8'h97; Repeat = 8'd3;
    Start = 1'b1; step(); Start = 1'b0; Repeat = 8'd1;
    for (int e = 1; e <= 14; e++) begin
      step();
      exp_pass = (e / 4 > 3) ? 3 : e / 4;
      tests_run++; if (Pass_count !== 8'(exp_pass) || Done !== (e >= 12)) begin fails++; $display("FAIL mp_edge%0d: got pass %0d done %b expected %0d %b", e, Pass_count, Done, exp_pass, (e >= 12)); end
      tests_run++; if (Load_bar !== !((e % 4 == 0) && e < 12)) begin fails++; $display("FAIL mp_load_edge%0d: got %b expected %b", e, Load_bar, !((e % 4 == 0) && e < 12)); end
    end
    clear_chain();
  endtask

  // Pause at 96 for four edges, then resume: terminal moves from edge 6 to 10.
  task automatic test_stop_resume();
    d_bcd = 8'h95; Repeat = 8'd1;
    Start = 1'b1; step(); Start = 1'b0;                      // edge 0
    step();                                                  // edge 1
    Stop = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      step();
      tests_run++; if (chain_val !== 96 || {ENP, ENT, Busy} !== 3'b011) begin fails++; $display("FAIL sr_hold_edge%0d: got chain %0d peb %b expected 96 011", e, chain_val, {ENP, ENT, Busy}); end
    end
    Stop = 1'b0; Start = 1'b1; step(); Start = 1'b0;         // edge 6
    tests_run++; if (chain_val !== 96 || ENP !== 1'b1) begin fails++; $display("FAIL sr_resume: got chain %0d enp %b expected 96 1", chain_val, ENP); end
    step(); step(); step();                                  // edge 9
    tests_run++; if (chain_val !== 99 || Done !== 1'b0) begin fails++; $display("FAIL sr_late_terminal: got chain %0d done %b expected 99 0", chain_val, Done); end
    step();                                                  // edge 10
    tests_run++; if (Done !== 1'b1 || Pass_count !== 8'd1) begin fails++; $display("FAIL sr_done: got done %b pass %0d expected 1 1", Done, Pass_count); end
    clear_chain();
  endtask

  // Stop coinciding with terminal is dropped; then abort with Clear_req.
  task automatic test_stop_at_terminal();
    d_bcd = 8'h95; Repeat = 8'd2;
    Start = 1'b1; step(); Start = 1'b0;
    for (int e = 1; e <= 5; e++) step();                     // chain 99
    Stop = 1'b1; step(); Stop = 1'b0;                        // edge 6
    tests_run++; if (Pass_count !== 8'd1 || {Load_bar, ENP, ENT, Busy} !== 4'b0001) begin fails++; $display("FAIL st_terminal_wins: got pass %0d lpeb %b expected 1 0001", Pass_count, {Load_bar, ENP, ENT, Busy}); end
    step();                                                  // edge 7
    tests_run++; if (ENP !== 1'b1 || chain_val !== 95) begin fails++; $display("FAIL st_second_pass: got enp %b chain %0d expected 1 95", ENP, chain_val); end
    step();                                                  // edge 8
    Clear_req = 1'b1; step(); Clear_req = 1'b0;              // edge 9
    tests_run++; if ({Clear_bar, Busy, ENP} !== 3'b000 || Pass_count !== 8'd1) begin fails++; $display("FAIL st_clear: got cbe %b pass %0d expected 000 1", {Clear_bar, Busy, ENP}, Pass_count); end
    step();                                                  // edge 10
    tests_run++; if (chain_val !== 0 || {Clear_bar, Busy, Done} !== 3'b100) begin fails++; $display("FAIL st_idle: got chain %0d cbd %b expected 0 100", chain_val, {Clear_bar, Busy, Done}); end
    step();
    tests_run++; if ({Load_bar, Busy} !== 2'b10) begin fails++; $display("FAIL st_stays_idle: got %b expected 10", {Load_bar, Busy}); end
  endtask

  // Reset mid-run, then Repeat=0 gives exactly one pass.
  task automatic test_reset_mid_run();
    d_bcd = 8'h95; Repeat = 8'd2;
    Start = 1'b1; step(); Start = 1'b0;
    step(); step(); step();                                  // chain 97
    tests_run++; if (chain_val !== 97) begin fails++; $display("FAIL rm_chain: got %0d expected 97", chain_val); end
    Reset = 1'b1; step(); Reset = 1'b0;
    tests_run++; if ({ENP, ENT, Busy, Done} !== 4'b0000 || Pass_count !== 8'd0) begin fails++; $display("FAIL rm_reset: got pebd %b pass %0d expected 0000 0", {ENP, ENT, Busy, Done}, Pass_count); end
    Repeat = 8'd0;
    Start = 1'b1; step(); Start = 1'b0;
    for (int e = 1; e <= 5; e++) step();
    tests_run++; if (Done !== 1'b0) begin fails++; $display("FAIL rm_early_done: got %b expected 0", Done); end
    step();
    tests_run++; if (Done !== 1'b1 || Pass_count !== 8'd1) begin fails++; $display("FAIL rm_one_pass: got done %b pass %0d expected 1 1", Done, Pass_count); end
    clear_chain();
  endtask

  // DONE behaviour: held (default) or one-cycle pulse with auto reload.
  task automatic test_done_hold();
    d_bcd = 8'h98; Repeat = 8'd1;
    Start = 1'b1; step(); Start = 1'b0;
    step(); step(); step();                                  // edge 3: DONE
    tests_run++; if (Done !== 1'b1 || Pass_count !== 8'd1) begin fails++; $display("FAIL dh_first_done: got done %b pass %0d expected 1 1", Done, Pass_count); end
`ifdef SEQ_AUTO_RELOAD_EN
    for (int e = 4; e <= 15; e++) begin
      step();
      tests_run++; if (Done !== ((e - 3) % 4 == 0) || Pass_count !== 8'(((e - 3) % 4 == 0) ? 1 : 0)) begin fails++; $display("FAIL dh_pulse_edge%0d: got done %b pass %0d", e, Done, Pass_count); end
    end
`else
    for (int e = 4; e <= 23; e++) begin
      step();
      tests_run++; if ({Done, Busy} !== 2'b10 || Pass_count !== 8'd1) begin fails++; $display("FAIL dh_held_edge%0d: got db %b pass %0d expected 10 1", e, {Done, Busy}, Pass_count); end
    end
    Repeat = 8'd2;
    Start = 1'b1; step(); Start = 1'b0;
    tests_run++; if ({Load_bar, Done} !== 2'b00 || Pass_count !== 8'd0) begin fails++; $display("FAIL dh_restart: got ld %b pass %0d expected 00 0", {Load_bar, Done}, Pass_count); end
    for (int e = 1; e <= 5; e++) step();
    tests_run++; if (Done !== 1'b0) begin fails++; $display("FAIL dh_restart_early: got %b expected 0", Done); end
    step();
    tests_run++; if (Done !== 1'b1 || Pass_count !== 8'd2) begin fails++; $display("FAIL dh_restart_done: got done %b pass %0d expected 1 2", Done, Pass_count); end
`endif
    clear_chain();
  endtask

  // Random presets, pass counts, optional pause and Start noise while running.
  task automatic test_random();
    int p, r_req, r_eff, len, do_stop, sp, m, h, stop_edge, resume_edge, done_edge;
    int exp_pass;
    bit exp_load_low, in_hold;
    int t[8];
    for (int it = 0; it < 20; it++) begin
      p = $urandom_range(80, 98);
      d_bcd = {4'(p / 10), 4'(p % 10)};
      r_req = $urandom_range(0, 4);
      r_eff = (r_req == 0) ? 1 : r_req;
      len = 101 - p;
      do_stop = $urandom_range(0, 1);
      sp = $urandom_range(0, r_eff - 1);
      m = $urandom_range(1, len - 2);
      h = $urandom_range(1, 5);
      stop_edge = sp * len + 1 + m;
      resume_edge = stop_edge + h;
      for (int j = 0; j < r_eff; j++) t[j] = (j + 1) * len + ((do_stop != 0 && j >= sp) ? h : 0);
      done_edge = t[r_eff - 1];
      Repeat = 8'(r_req);
      Start = 1'b1; step(); Start = 1'b0;
      Repeat = 8'($urandom);
      tests_run++; if (Load_bar !== 1'b0) begin fails++; $display("FAIL rnd%0d_start_load: got %b expected 0", it, Load_bar); end
      for (int e = 1; e <= done_edge; e++) begin
        in_hold = (do_stop != 0) && e > stop_edge && e <= resume_edge;
        Stop  = (do_stop != 0) && e == stop_edge;
        Start = ((do_stop != 0) && e == resume_edge) || (!in_hold && $urandom_range(0, 3) == 0);
        step();
        Stop = 1'b0; Start = 1'b0;
        exp_pass = 0; exp_load_low = 1'b0;
        for (int j = 0; j < r_eff; j++) begin
          if (t[j] <= e) exp_pass++;
          if (t[j] == e && j < r_eff - 1) exp_load_low = 1'b1;
        end
        tests_run++; if (Pass_count !== 8'(exp_pass) || Done !== (e == done_edge) || Busy !== (e != done_edge)) begin fails++; $display("FAIL rnd%0d_edge%0d: got pass %0d done %b busy %b expected %0d %b %b", it, e, Pass_count, Done, Busy, exp_pass, (e == done_edge), (e != done_edge)); end
        tests_run++; if (Load_bar !== !exp_load_low) begin fails++; $display("FAIL rnd%0d_load_edge%0d: got %b expected %b", it, e, Load_bar, !exp_load_low); end
        if (do_stop != 0 && e >= stop_edge && e < resume_edge) begin
          tests_run++; if ({ENP, ENT} !== 2'b01) begin fails++; $display("FAIL rnd%0d_hold_edge%0d: got %b expected 01", it, e, {ENP, ENT}); end
        end
      end
      tests_run++; if (chain_val !== 0) begin fails++; $display("FAIL rnd%0d_wrap: got %0d expected 0", it, chain_val); end
      clear_chain();
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; Clear_req = 1'b0; Repeat = 8'd1;
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_stop_resume();
    test_stop_at_terminal();
    test_reset_mid_run();
    test_done_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
